// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 round sequencer: drives an external single-round datapath
// through the initial AddRoundKey, NR-1 full rounds and the final round.
module aes_round_sequencer #(
    parameter int NR = 10,
    localparam int KEY_W = 128 * (NR + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_block,
    input  logic [KEY_W-1:0] in_w,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_block,
    output logic [127:0]     dp_state,
    output logic [127:0]     dp_key,
    output logic [1:0]       dp_mode,
    input  logic [127:0]     dp_result,
    output logic             busy,
    output logic [3:0]       round
);

    localparam logic [3:0] LAST = 4'(NR);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         round_q, round_d;
    logic [127:0]       blk_q, blk_d;
    logic [127:0]       out_q, out_d;
    logic [KEY_W-1:0]   key_q, key_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            round_q <= '0;
            blk_q   <= '0;
            key_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            blk_q   <= blk_d;
            key_q   <= key_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        blk_d   = blk_q;
        key_d   = key_q;
        out_d   = out_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    blk_d   = in_block;
                    key_d   = in_w;
                    round_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                blk_d = dp_result;
                if (round_q == LAST) begin
                    out_d   = dp_result;
                    state_d = DONE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    round_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outside RUN the datapath sees round-0 settings and its result is unused.
    always_comb begin
        dp_key  = key_q[KEY_W-1 -: 128];
        dp_mode = 2'b00;
        if (state_q == RUN) begin
            for (int r = 1; r <= NR; r++) begin
                if (round_q == 4'(r)) begin
                    dp_key = key_q[KEY_W-1-128*r -: 128];
                end
            end
            if (round_q == LAST) begin
                dp_mode = 2'b10;
            end else if (round_q != 4'd0) begin
                dp_mode = 2'b01;
            end
        end
    end

    assign dp_state  = blk_q;
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign round     = round_q;
    assign out_block = out_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Randomized scoreboard bench for aes_round_sequencer with a behavioural
// AES-128 round model on the datapath port and a full-cipher reference.
module tb_aes_round_sequencer;

    localparam int NR    = 10;
    localparam int KEY_W = 128 * (NR + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_block;
    logic [KEY_W-1:0] in_w;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out_block;
    logic [127:0]     dp_state;
    logic [127:0]     dp_key;
    logic [1:0]       dp_mode;
    logic [127:0]     dp_result;
    logic             busy;
    logic [3:0]       round;

    aes_round_sequencer #(.NR(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_block  (in_block),
        .in_w      (in_w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .dp_state  (dp_state),
        .dp_key    (dp_key),
        .dp_mode   (dp_mode),
        .dp_result (dp_result),
        .busy      (busy),
        .round     (round)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [127:0] act,
                         input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic checkb(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- AES reference ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r, p, e;
        r = 8'h01;
        p = x;
        e = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, p);
            p = gmul(p, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] st,
                                               input logic [127:0] key,
                                               input logic [1:0] mode);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   t0, t1, t2, t3;
        logic [127:0] res;
        if (mode == 2'b00) return st ^ key;
        if (mode == 2'b11) return st;
        for (int i = 0; i < 16; i++) a[i] = sbox(st[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[r+4*c] = a[r+4*((c+r)%4)];
        if (mode == 2'b01) begin
            for (int c = 0; c < 4; c++) begin
                t0 = b[4*c]; t1 = b[4*c+1]; t2 = b[4*c+2]; t3 = b[4*c+3];
                b[4*c]   = gmul(8'h02, t0) ^ gmul(8'h03, t1) ^ t2 ^ t3;
                b[4*c+1] = t0 ^ gmul(8'h02, t1) ^ gmul(8'h03, t2) ^ t3;
                b[4*c+2] = t0 ^ t1 ^ gmul(8'h02, t2) ^ gmul(8'h03, t3);
                b[4*c+3] = gmul(8'h03, t0) ^ t1 ^ t2 ^ gmul(8'h02, t3);
            end
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = b[i];
        return res ^ key;
    endfunction

    function automatic logic [KEY_W-1:0] expand(input logic [127:0] key);
        logic [31:0]      w [44];
        logic [31:0]      t;
        logic [7:0]       rc;
        logic [KEY_W-1:0] o;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])}
                    ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) o[KEY_W-1-32*i -: 32] = w[i];
        return o;
    endfunction

    function automatic logic [127:0] rk(input logic [KEY_W-1:0] w, input int r);
        return w[KEY_W-1-128*r -: 128];
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt,
                                             input logic [KEY_W-1:0] w);
        logic [127:0] s;
        s = aes_round(pt, rk(w, 0), 2'b00);
        for (int r = 1; r < NR; r++) s = aes_round(s, rk(w, r), 2'b01);
        return aes_round(s, rk(w, NR), 2'b10);
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    always_comb dp_result = aes_round(dp_state, dp_key, dp_mode);

    // ---------------- scoreboard / monitor ----------------
    logic [127:0]     exp_q [$];
    logic [KEY_W-1:0] cur_w;
    bit               running = 0;
    bit               chk_b2b = 0;
    bit               b2b_acc = 0;
    bit               prev_ov = 0;
    int               tb_round = 0;
    int               acc_edge = 0;
    int               hs_edge  = 0;
    int               fall_cyc = 0;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            running = 0;
            prev_ov = 0;
        end else begin
            if (running) begin
                checkb("run_busy", int'(busy), 1);
                checkb("run_in_ready", int'(in_ready), 0);
                checkb("run_round", int'(round), tb_round);
                checkb("run_dp_mode", int'(dp_mode),
                       tb_round == 0 ? 0 : (tb_round == NR ? 2 : 1));
                check("run_dp_key", dp_key, rk(cur_w, tb_round));
                tb_round++;
                if (tb_round > NR) running = 0;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(encrypt(in_block, in_w));
                cur_w    = in_w;
                running  = 1;
                tb_round = 0;
                acc_edge = cyc + 1;
                b2b_acc  = chk_b2b;
                if (b2b_acc) checkb("b2b_accept_edge", acc_edge, hs_edge + 1);
            end
            if (out_valid && !prev_ov) begin
                checkb("latency", cyc - acc_edge, NR + 1);
                if (b2b_acc) checkb("b2b_spacing", cyc - fall_cyc, NR + 2);
            end
            if (!out_valid && prev_ov) fall_cyc = cyc;
            if (out_valid && out_ready) begin
                hs_edge = cyc + 1;
                if (exp_q.size() == 0) begin
                    checkb("unexpected_output", 1, 0);
                end else begin
                    check("out_block", out_block, exp_q.pop_front());
                end
            end
            prev_ov = out_valid;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [127:0] b, input logic [KEY_W-1:0] w,
                        input bit keep);
        bit ok;
        @(posedge clk); #1;
        in_block = b;
        in_w     = w;
        in_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        if (!keep) in_valid = 1'b0;
        if (!ok) checkb("accept_timeout", 0, 1);
    endtask

    task automatic wait_out();
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1; break; end
        end
        if (!ok) checkb("out_valid_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) begin ok = 1; break; end
        end
        if (!ok) checkb("idle_timeout", 0, 1);
    endtask

    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KC1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    initial begin
        logic [127:0]     pa, pb;
        logic [KEY_W-1:0] wa, wb;
        bit               ok;
        int               seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_block  = '0;
        in_w      = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkb("rst_in_ready", int'(in_ready), 1);
        checkb("rst_busy", int'(busy), 0);
        checkb("rst_out_valid", int'(out_valid), 0);
        checkb("rst_round", int'(round), 0);
        check("rst_out_block", out_block, '0);
        check("rst_dp_state", dp_state, '0);
        checkb("rst_dp_mode", int'(dp_mode), 0);

        // FIPS-197 C.1
        send(PT, expand(KC1), 0);
        @(negedge clk);
        checkb("c1_r0_mode", int'(dp_mode), 0);
        check("c1_r0_key", dp_key, KC1);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (round == 4'd10) begin ok = 1; break; end
            @(negedge clk);
        end
        checkb("c1_reach_r10", int'(ok), 1);
        checkb("c1_r10_mode", int'(dp_mode), 2);
        check("c1_r10_key", dp_key, K10);
        wait_out();
        check("c1_ciphertext", out_block, CT);
        wait_idle();

        // backpressure, then a queued block accepted after the drain
        pa = rand128();
        wa = expand(rand128());
        out_ready = 1'b0;
        send(pa, wa, 0);
        wait_out();
        @(posedge clk); #1;
        in_block = rand128();
        in_w     = expand(rand128());
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkb("bp_out_valid", int'(out_valid), 1);
            check("bp_out_block", out_block, encrypt(pa, wa));
            checkb("bp_in_ready", int'(in_ready), 0);
            if (i < 4) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkb("drain_busy", int'(busy), 0);
        checkb("drain_in_ready", int'(in_ready), 1);
        checkb("drain_out_valid", int'(out_valid), 0);
        @(posedge clk); #1 in_valid = 1'b0;
        wait_idle();

        // back-to-back with in_valid held high
        pa = rand128(); wa = expand(rand128());
        pb = rand128(); wb = expand(rand128());
        send(pa, wa, 1);
        in_block = pb;
        in_w     = wb;
        chk_b2b  = 1;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        checkb("b2b_second_accept", int'(ok), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk_b2b  = 0;
        wait_idle();

        // reset while round 5 is in flight
        send(rand128(), expand(rand128()), 0);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (round == 4'd4) begin ok = 1; break; end
        end
        checkb("abort_reach_r4", int'(ok), 1);
        @(posedge clk); #1;
        checkb("abort_round5", int'(round), 5);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checkb("abort_busy", int'(busy), 0);
        checkb("abort_round", int'(round), 0);
        checkb("abort_out_valid", int'(out_valid), 0);
        checkb("abort_in_ready", int'(in_ready), 1);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checkb("abort_no_output", seen, 0);

        // random blocks with inputs scrambled after acceptance
        for (int n = 0; n < 4; n++) begin
            send(rand128(), expand(rand128()), 0);
            for (int i = 0; i < 12; i++) begin
                @(posedge clk); #1;
                in_block = rand128();
                for (int k = 0; k < KEY_W / 32; k++)
                    in_w[32*k +: 32] = $urandom;
            end
            wait_idle();
        end

        checkb("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
